fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the RV32E pipeline.
- Replaces the single-register IF/ID path and its inst_ready stall with an in-order prefetch queue.
- Supports a variable-latency instruction memory, several outstanding requests and flush-on-redirect with discard of in-flight responses.
- Sits between the instruction memory port and the decoder; redirects come from the branch/jump logic.

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fetch_queue_fifo_sync.sv | 54 +++++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the RV32E instruction-fetch front end.
// Holds the NOP encoding, the queue entry layout and the front-end state enum.
package fetch_queue_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_RESET = 1'b0,
      ST_RUN   = 1'b1
   } fq_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory port bundle between the fetch queue and the memory.
// The fetch queue drives requests as master; the memory answers as slave.
interface fetch_queue_if #(
   parameter int XLEN = 32
) ();

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] addr;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_data;

   modport master (
      output req_valid,
      output addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/fetch_queue_fifo_sync.sv
// Synchronous circular-buffer FIFO with occupancy count and synchronous clear.
// The head is always presented from registered storage; push and pop may coincide when full.
module fifo_sync #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CW-1:0]    occupancy
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full      = (occupancy == CW'(DEPTH));
   assign empty     = (occupancy == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear wins over any push or pop.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_queue.sv
// In-order prefetch queue feeding the decoder from a variable-latency instruction memory.
// Tracks request credits, discards responses belonging to flushed fetches, and pairs each kept word with its PC.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2,
   parameter int XLEN            = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  boot_addr,
   fetch_queue_if.master    imem,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [XLEN-1:0]  if_instr,
   output logic [XLEN-1:0]  if_pc,
   output logic [XLEN-1:0]  if_pc_plus_4
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int QW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   fq_state_t         state;
   fq_state_t         state_next;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [XLEN-1:0]   redirect_aligned;
   logic [OW-1:0]     outstanding;
   logic [OW-1:0]     drop_cnt;
   logic [QW-1:0]     occupancy;
   logic [SW-1:0]     credit_used;
   logic [2*XLEN-1:0] head_data;
   logic              q_empty;
   logic              run;
   logic              issue;
   logic              rsp_counted;
   logic              rsp_keep;
   logic              pop;

   assign redirect_aligned = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_RESET;
      else        state <= state_next;
   end

   // Outstanding counts every unanswered request, including the ones already marked
   // for discard, so credits stay conservative and drop_cnt can never exceed it.
   always_comb begin
      state_next     = ST_RUN;
      run            = (state == ST_RUN);
      credit_used    = SW'(occupancy) + SW'(outstanding);
      imem.req_valid = run && !redirect_valid
                       && (outstanding < OW'(MAX_OUTSTANDING))
                       && (credit_used < SW'(DEPTH));
      issue          = imem.req_valid && imem.req_ready;
      rsp_counted    = run && imem.rsp_valid && (outstanding != '0);
      rsp_keep       = rsp_counted && (drop_cnt == '0) && !redirect_valid;
      if_valid       = run && !q_empty && !redirect_valid;
      pop            = if_valid && if_ready;
   end

   assign imem.addr = fetch_pc;

   // On redirect every request still in flight after this cycle becomes a discard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc    <= boot_addr;
         rsp_pc      <= boot_addr;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (run) begin
         outstanding <= outstanding + OW'(issue) - OW'(rsp_counted);
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            drop_cnt <= outstanding - OW'(rsp_counted);
         end else begin
            if (issue)    fetch_pc <= fetch_pc + XLEN'(4);
            if (rsp_keep) rsp_pc   <= rsp_pc + XLEN'(4);
            if (rsp_counted && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
         end
      end
   end

   fifo_sync #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (redirect_valid),
      .push      (rsp_keep),
      .push_data ({rsp_pc, imem.rsp_data}),
      .pop       (pop),
      .head_data (head_data),
      .empty     (q_empty),
      .occupancy (occupancy)
   );

   assign if_pc        = head_data[2*XLEN-1:XLEN];
   assign if_instr     = if_valid ? head_data[XLEN-1:0] : XLEN'(NOP_INSTR);
   assign if_pc_plus_4 = if_pc + XLEN'(4);

   // A response with nothing in flight is a leftover from before reset and is ignored.
   stray_response_check : assert property (@(posedge clk) disable iff (!rst_n)
      (run && imem.rsp_valid) |-> ((outstanding != '0) || (drop_cnt != '0)))
      else $warning("fetch_queue: stray instruction-memory response ignored");

   occupancy_bound_check : assert property (@(posedge clk) disable iff (!rst_n)
      occupancy <= QW'(DEPTH))
      else $error("fetch_queue: queue occupancy above DEPTH");

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: ordered variable-latency memory, random decoder
// back-pressure and redirects, checked each cycle against a request/queue level model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int MAXO  = 2;
   localparam int XLEN  = 32;

   typedef struct {
      logic [31:0] pc;
      bit          doomed;
   } flight_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } mem_rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] boot_addr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus_4;

   fetch_queue_if #(.XLEN(XLEN)) imem_bus ();

   fetch_queue #(
      .DEPTH           (DEPTH),
      .MAX_OUTSTANDING (MAXO),
      .XLEN            (XLEN)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .boot_addr      (boot_addr),
      .imem           (imem_bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus_4   (if_pc_plus_4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;
   int cycle  = 0;

   int          mem_lat        = 1;
   bit          rand_ready     = 1'b0;
   int          if_ready_pct   = 100;
   int          redirect_pct   = 0;
   bit          force_redirect = 1'b0;
   logic [31:0] force_pc       = '0;
   bit          rst_drv        = 1'b0;
   mem_rsp_t    mem_q[$];
   int          last_due       = 0;

   bit           m_run = 1'b0;
   logic [31:0]  m_fetch_pc = '0;
   fetch_entry_t m_q[$];
   flight_t      m_flight[$];

   int          release_cycle     = 0;
   int          first_valid_cycle = -1;
   logic [31:0] first_pc          = '0;
   logic [31:0] first_pc4         = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: actual=%b expected=%b (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Drives reset, memory ready/response, decoder ready and redirect for one cycle.
   task automatic applyStimulus();
      rst_n = rst_drv;
      imem_bus.req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mem_q.size() > 0 && mem_q[0].due == cycle) begin
         imem_bus.rsp_valid = 1'b1;
         imem_bus.rsp_data  = mem_q[0].data;
         mem_q.delete(0);
      end else begin
         imem_bus.rsp_valid = 1'b0;
         imem_bus.rsp_data  = $urandom();
      end
      if_ready = ($urandom_range(1, 100) <= if_ready_pct);
      if (force_redirect) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redirect = 1'b0;
      end else if (redirect_pct > 0 && $urandom_range(1, 100) <= redirect_pct) begin
         redirect_valid = 1'b1;
         redirect_pc    = $urandom();
      end else begin
         redirect_valid = 1'b0;
         redirect_pc    = $urandom();
      end
   endtask

   // Compares DUT outputs with the model, then advances memory and model across the edge.
   task automatic checkOutput();
      bit      exp_req;
      bit      exp_ifv;
      bit      issue;
      flight_t f;
      int      due;
      exp_req = m_run && !redirect_valid && (m_flight.size() < MAXO)
                && ((m_q.size() + m_flight.size()) < DEPTH);
      exp_ifv = m_run && (m_q.size() > 0) && !redirect_valid;
      checkBit("imem_req_valid", imem_bus.req_valid, exp_req);
      if (exp_req) checkWord("imem_addr", imem_bus.addr, m_fetch_pc);
      checkBit("if_valid", if_valid, exp_ifv);
      if (exp_ifv) begin
         checkWord("if_pc", if_pc, m_q[0].pc);
         checkWord("if_pc_plus_4", if_pc_plus_4, m_q[0].pc + 32'd4);
         checkWord("if_instr", if_instr, m_q[0].instr);
      end else begin
         checkWord("if_instr_nop", if_instr, NOP_INSTR);
      end

      if (if_valid && first_valid_cycle < 0) begin
         first_valid_cycle = cycle;
         first_pc          = if_pc;
         first_pc4         = if_pc_plus_4;
      end

      if (rst_n && imem_bus.req_valid && imem_bus.req_ready) begin
         due = cycle + mem_lat;
         if (due <= last_due) due = last_due + 1;
         mem_q.push_back('{data: mem_word(imem_bus.addr), due: due});
         last_due = due;
      end

      if (!rst_n) begin
         m_run      = 1'b0;
         m_fetch_pc = boot_addr;
         m_q.delete();
         m_flight.delete();
         mem_q.delete();
         last_due = cycle;
      end else if (!m_run) begin
         m_run = 1'b1;
      end else begin
         issue = exp_req && imem_bus.req_ready;
         if (exp_ifv && if_ready) m_q.delete(0);
         if (imem_bus.rsp_valid && m_flight.size() > 0) begin
            f = m_flight[0];
            m_flight.delete(0);
            if (!f.doomed && !redirect_valid)
               m_q.push_back('{pc: f.pc, instr: mem_word(f.pc)});
         end
         if (redirect_valid) begin
            m_q.delete();
            foreach (m_flight[i]) m_flight[i].doomed = 1'b1;
            m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
         end
         if (issue) begin
            m_flight.push_back('{pc: m_fetch_pc, doomed: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      cycle++;
   endtask

   task automatic step();
      @(negedge clk);
      applyStimulus();
      #4;
      checkOutput();
   endtask

   task automatic waitValid(input string name, input int limit);
      int n = 0;
      while (!if_valid && n < limit) begin
         step();
         n++;
      end
      checkBit(name, if_valid, 1'b1);
   endtask

   task automatic restart(input logic [31:0] boot);
      boot_addr = boot;
      rst_drv   = 1'b0;
      repeat (2) step();
      rst_drv   = 1'b1;
   endtask

   initial begin
      rst_n              = 1'b0;
      boot_addr          = 32'h0000_0100;
      redirect_valid     = 1'b0;
      redirect_pc        = '0;
      if_ready           = 1'b0;
      imem_bus.req_ready = 1'b0;
      imem_bus.rsp_valid = 1'b0;
      imem_bus.rsp_data  = '0;

      // Boot fetch with a 1-cycle memory and a always-ready decoder.
      repeat (3) step();
      checkBit("reset_req_valid", imem_bus.req_valid, 1'b0);
      checkBit("reset_if_valid", if_valid, 1'b0);
      checkWord("reset_if_instr", if_instr, 32'h0000_0013);
      rst_drv       = 1'b1;
      release_cycle = cycle;
      repeat (2) step();
      checkBit("first_req_valid", imem_bus.req_valid, 1'b1);
      checkWord("first_req_addr", imem_bus.addr, 32'h0000_0100);
      repeat (10) step();
      checkWord("first_valid_latency", 32'(first_valid_cycle - release_cycle), 32'd3);
      checkWord("first_if_pc", first_pc, 32'h0000_0100);
      checkWord("first_if_pc_plus_4", first_pc4, 32'h0000_0104);

      // Back-pressured fill, then drain.
      if_ready_pct = 0;
      restart(32'h0000_0100);
      repeat (12) step();
      checkBit("fill_if_valid", if_valid, 1'b1);
      checkWord("fill_head_pc", if_pc, 32'h0000_0100);
      checkBit("fill_req_stalled", imem_bus.req_valid, 1'b0);
      if_ready_pct = 100;
      repeat (10) step();

      // Reset in the middle of a back-pressured fill, restarting at a new boot address.
      if_ready_pct = 0;
      repeat (3) step();
      boot_addr = 32'h0000_0400;
      rst_drv   = 1'b0;
      repeat (2) step();
      checkBit("midreset_req_valid", imem_bus.req_valid, 1'b0);
      checkBit("midreset_if_valid", if_valid, 1'b0);
      rst_drv = 1'b1;
      repeat (2) step();
      checkWord("midreset_restart_addr", imem_bus.addr, 32'h0000_0400);

      // Redirect with two requests in flight on a 3-cycle memory.
      mem_lat      = 3;
      if_ready_pct = 100;
      restart(32'h0000_0100);
      repeat (3) step();
      force_redirect = 1'b1;
      force_pc       = 32'h0000_0200;
      step();
      waitValid("redirect_refill_timeout", 20);
      checkWord("redirect_head_pc", if_pc, 32'h0000_0200);
      checkWord("redirect_head_instr", if_instr, mem_word(32'h0000_0200));

      // Redirect coinciding with a response and a ready decoder.
      mem_lat = 1;
      restart(32'h0000_0100);
      repeat (8) step();
      force_redirect = 1'b1;
      force_pc       = 32'h0000_0303;
      step();
      checkBit("redirect_forces_if_valid_low", if_valid, 1'b0);
      step();
      checkBit("redirect_restart_req", imem_bus.req_valid, 1'b1);
      checkWord("redirect_restart_addr", imem_bus.addr, 32'h0000_0300);

      // Redirect to the top of the address space.
      if_ready_pct = 0;
      repeat (10) step();
      force_redirect = 1'b1;
      force_pc       = 32'hFFFF_FFFC;
      step();
      step();
      checkWord("wrap_first_addr", imem_bus.addr, 32'hFFFF_FFFC);
      step();
      checkWord("wrap_second_addr", imem_bus.addr, 32'h0000_0000);
      step();
      checkWord("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      checkWord("wrap_if_pc_plus_4", if_pc_plus_4, 32'h0000_0000);

      // Randomized traffic: memory stalls, latencies, back-pressure, redirects and resets.
      rand_ready   = 1'b1;
      redirect_pct = 4;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) mem_lat = $urandom_range(1, 4);
         if (i % 250 == 0) if_ready_pct = $urandom_range(10, 100);
         if ($urandom_range(0, 299) == 0) begin
            rst_drv   = 1'b0;
            boot_addr = $urandom() & 32'hFFFF_FFFC;
         end else begin
            rst_drv = 1'b1;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
